ttl_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared TTL-style buffered bus: one 3-to-8 decoder (74138-type) selects the device, and a dual-nibble octal buffer (74244-type) gates the data path. Up to eight requesters compete for the bus. The block drives the decoder select/enable pins and the two buffer gate enables. Every grant runs through an address-setup cycle, a gated transfer and a turnaround gap, so the bus is never enabled while the decoder address is changing.

---
 rtl/ttl_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_ttl_bus_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ttl_bus_arbiter.sv
// Round-robin arbiter for a 74138-decoded, 74244-buffered TTL bus: setup, gated transfer, turnaround.
// Optional grant timeout is compiled in with `define TTL_ARB_TIMEOUT_EN.
module ttl_bus_arbiter #(
  parameter int unsigned HOLD_MAX   = 16,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] req_wide,
  output logic [2:0] A,
  output logic       E1_n,
  output logic       E2_n,
  output logic       E3,
  output logic       G1_n,
  output logic       G2_n,
  output logic       gnt_valid,
  output logic [2:0] gnt_id
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("ttl_bus_arbiter: HOLD_MAX out of range 1..255");
  end
  if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
    $error("ttl_bus_arbiter: TURNAROUND out of range 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_GRANT = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  localparam logic [3:0] L_TURN_LOAD = 4'(TURNAROUND - 1);

  state_t     r_state;
  logic [2:0] r_last;
  logic       r_wide;
  logic [3:0] r_turn_cnt;

  logic [2:0] w_winner;
  logic [2:0] w_idx;
  logic       w_timeout;

  // Scan from farthest to nearest so the requester just after r_last is assigned last and wins.
  always_comb begin
    w_winner = r_last;
    w_idx    = r_last;
    for (int k = 8; k >= 1; k--) begin
      w_idx = r_last + 3'(k);
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

`ifdef TTL_ARB_TIMEOUT_EN
  localparam logic [7:0] L_HOLD_MAX = 8'(HOLD_MAX);
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_next;

  assign w_hold_next = r_hold_cnt + 8'd1;
  assign w_timeout   = (w_hold_next >= L_HOLD_MAX);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= 3'd7;
      r_wide     <= 1'b0;
      r_turn_cnt <= 4'd0;
      A          <= 3'b000;
      gnt_id     <= 3'b000;
      E1_n       <= 1'b1;
      E2_n       <= 1'b1;
      E3         <= 1'b0;
      G1_n       <= 1'b1;
      G2_n       <= 1'b1;
      gnt_valid  <= 1'b0;
`ifdef TTL_ARB_TIMEOUT_EN
      r_hold_cnt <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req != 8'h00) begin
            A       <= w_winner;
            gnt_id  <= w_winner;
            r_wide  <= req_wide[w_winner];
            E1_n    <= 1'b0;
            E2_n    <= 1'b0;
            E3      <= 1'b1;
            r_state <= S_SETUP;
`ifdef TTL_ARB_TIMEOUT_EN
            r_hold_cnt <= 8'd0;
`endif
          end
        end

        S_SETUP: begin
          if (req[gnt_id]) begin
            r_state   <= S_GRANT;
            gnt_valid <= 1'b1;
            G1_n      <= 1'b0;
            G2_n      <= ~r_wide;
            r_last    <= gnt_id;
          end else begin
            // Aborted setup: pointer stays put so the aborting requester keeps its priority.
            r_state    <= S_TURN;
            E1_n       <= 1'b1;
            E2_n       <= 1'b1;
            E3         <= 1'b0;
            r_turn_cnt <= L_TURN_LOAD;
          end
        end

        S_GRANT: begin
`ifdef TTL_ARB_TIMEOUT_EN
          r_hold_cnt <= w_hold_next;
`endif
          if (!req[gnt_id] || w_timeout) begin
            r_state    <= S_TURN;
            gnt_valid  <= 1'b0;
            G1_n       <= 1'b1;
            G2_n       <= 1'b1;
            E1_n       <= 1'b1;
            E2_n       <= 1'b1;
            E3         <= 1'b0;
            r_turn_cnt <= L_TURN_LOAD;
          end
        end

        S_TURN: begin
          if (r_turn_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_turn_cnt <= r_turn_cnt - 4'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttl_bus_arbiter.sv
// Bench for ttl_bus_arbiter: directed steps plus random traffic against a tenure-level reference model.
module tb_ttl_bus_arbiter;

  localparam int HOLD_MAX   = 4;
  localparam int TURNAROUND = 2;
`ifdef TTL_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_SETUP = 1;
  localparam int P_GRANT = 2;
  localparam int P_TURN  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] req_wide;
  logic [2:0] A;
  logic       E1_n, E2_n, E3, G1_n, G2_n, gnt_valid;
  logic [2:0] gnt_id;

  int tests = 0;
  int fails = 0;

  int m_ph, m_owner, m_last, m_wide, m_hold, m_tleft;

  ttl_bus_arbiter #(.HOLD_MAX(HOLD_MAX), .TURNAROUND(TURNAROUND)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wide(req_wide),
    .A(A), .E1_n(E1_n), .E2_n(E2_n), .E3(E3), .G1_n(G1_n), .G2_n(G2_n),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_owner = 0; m_last = 7; m_wide = 0; m_hold = 0; m_tleft = 0;
  endtask

  // One rising edge of the bus protocol, from the current req/req_wide.
  task automatic model_step();
    int w;
    case (m_ph)
      P_IDLE: if (req != 8'h00) begin
        w = -1;
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (m_last + k) % 8;
          if (w < 0 && req[c]) w = c;
        end
        m_owner = w;
        m_wide  = int'(req_wide[w]);
        m_hold  = 0;
        m_ph    = P_SETUP;
      end
      P_SETUP: if (req[m_owner]) begin
        m_ph = P_GRANT; m_last = m_owner; m_hold = 0;
      end else begin
        m_ph = P_TURN; m_tleft = TURNAROUND;
      end
      P_GRANT: begin
        m_hold++;
        if (!req[m_owner] || (TO_EN && m_hold >= HOLD_MAX)) begin
          m_ph = P_TURN; m_tleft = TURNAROUND;
        end
      end
      default: begin
        m_tleft--;
        if (m_tleft == 0) m_ph = P_IDLE;
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    bit dec_on, granted;
    dec_on  = (m_ph == P_SETUP) || (m_ph == P_GRANT);
    granted = (m_ph == P_GRANT);
    chk({tag, ".A"},      8'(A),      8'(m_owner));
    chk({tag, ".gnt_id"}, 8'(gnt_id), 8'(m_owner));
    chk({tag, ".dec"},    {5'b0, E1_n, E2_n, E3}, dec_on ? 8'h01 : 8'h06);
    chk({tag, ".gvalid"}, {7'b0, gnt_valid}, {7'b0, granted});
    chk({tag, ".gates"},  {6'b0, G1_n, G2_n},
        {6'b0, ~granted, ~(granted && (m_wide != 0))});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".A"},      8'(A),      8'h00);
    chk({tag, ".gnt_id"}, 8'(gnt_id), 8'h00);
    chk({tag, ".pins"}, {2'b0, E1_n, E2_n, E3, G1_n, G2_n, gnt_valid}, 8'b0011_0110);
  endtask

  task automatic cycle(input string tag, input logic [7:0] r, input logic [7:0] rw);
    @(negedge clk);
    req = r;
    req_wide = rw;
    @(posedge clk);
    model_step();
    #1 check_model(tag);
  endtask

  initial begin
    logic [7:0] r, rw;
    rst_n = 1'b0; req = 8'h00; req_wide = 8'h00;
    model_reset();
    #12 check_reset("reset");
    @(negedge clk) rst_n = 1'b1;

    // First request after reset: decoder on one edge later, gates one edge after that.
    cycle("first.setup", 8'h01, 8'h00);
    chk("first.setup.E3", {7'b0, E3}, 8'h01);
    cycle("first.grant", 8'h01, 8'h00);
    chk("first.grant.pins", {5'b0, G1_n, G2_n, gnt_valid}, 8'b0000_0011);
    cycle("first.hold", 8'h01, 8'h00);
    repeat (4) cycle("first.rel", 8'h00, 8'h00);

    // Contention between 0 and 7, 0 drops after a few grant cycles.
    repeat (5) cycle("cont.a", 8'h81, 8'h00);
    repeat (12) cycle("cont.b", 8'h80, 8'h00);
    repeat (4) cycle("cont.c", 8'h00, 8'h00);

    // Abort: one-cycle pulse on 2, then 2 and 3 together.
    cycle("abort.pulse", 8'h04, 8'h00);
    repeat (4) cycle("abort.turn", 8'h00, 8'h00);
    repeat (6) cycle("abort.next", 8'h0C, 8'h00);
    repeat (4) cycle("abort.rel", 8'h00, 8'h00);

    // Wide grant with req_wide[4] toggled mid-tenure.
    repeat (3) cycle("wide.a", 8'h10, 8'h10);
    repeat (2) cycle("wide.b", 8'h10, 8'h00);
    repeat (2) cycle("wide.c", 8'h10, 8'h10);
    repeat (4) cycle("wide.rel", 8'h00, 8'h00);

    // Requesters 0 and 1 held: with timeout enabled the grants alternate.
    repeat (30) cycle("pair", 8'h03, 8'h02);
    repeat (5) cycle("pair.rel", 8'h00, 8'h00);

    // Asynchronous reset in the middle of a grant.
    repeat (4) cycle("mid.grant", 8'h20, 8'h20);
    #1 rst_n = 1'b0;
    req = 8'h00;
    #1 check_reset("async_rst");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) cycle("post_rst", 8'h21, 8'h00);
    repeat (4) cycle("post_rst.rel", 8'h00, 8'h00);

    // Random traffic: patterns held for a few cycles, sometimes sparse.
    r = 8'h00; rw = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: r = 8'($urandom);
          1: r = 8'($urandom) & 8'($urandom) & 8'($urandom);
          2: r = 8'h00;
          default: r = r ^ (8'h01 << $urandom_range(0, 7));
        endcase
        rw = 8'($urandom);
      end
      cycle("rand", r, rw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
